// File: rtl/token_fifo_pkg.sv
// Shared types and constants for the token FIFO between two dataflow actors.
// Build with TOKEN_FIFO_ERR_EN defined to add the sticky Err output.
package token_fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef logic [15:0] count_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_e;

    function automatic int ptr_w(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/token_fifo_if.sv
// Producer/consumer token handshake bundle.
// The master drives tokens in and acks tokens out; the slave is the FIFO.
interface token_fifo_if
    import token_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] In_DATA;
    logic             In_SEND;
    count_t           In_COUNT;
    logic             In_RDY;
    logic             In_ACK;
    logic [WIDTH-1:0] Out_DATA;
    logic             Out_SEND;
    count_t           Out_COUNT;
    logic             Out_ACK;

    modport master (
        output In_DATA, In_SEND, In_COUNT, Out_ACK,
        input  In_RDY, In_ACK, Out_DATA, Out_SEND, Out_COUNT
    );

    modport slave (
        input  In_DATA, In_SEND, In_COUNT, Out_ACK,
        output In_RDY, In_ACK, Out_DATA, Out_SEND, Out_COUNT
    );

endinterface

// File: rtl/token_fifo_mem.sv
// Token storage: one synchronous write port, one combinational read port.
// Contents are never cleared; occupancy tracking lives in the parent.
module token_fifo_mem
    import token_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/token_fifo.sv
// Token FIFO joining a producer actor's output port to a consumer's input port.
// Optional sticky protocol-error flag Err when TOKEN_FIFO_ERR_EN is defined.
module token_fifo
    import token_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         CLK,
    input  logic         RESET,
    token_fifo_if.slave  bus
`ifdef TOKEN_FIFO_ERR_EN
    ,
    output logic         Err
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);

    occ_state_e    state;
    occ_state_e    state_n;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_n;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          in_rdy;
    logic          out_send;
    logic          wr;
    logic          rd;
    logic          unused_count;

    // Producer count is always one token per send.
    assign unused_count = ^bus.In_COUNT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= EMPTY;
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_n;
            occ    <= occ_n;
            wr_ptr <= wr_ptr + PW'(wr);
            rd_ptr <= rd_ptr + PW'(rd);
        end
    end

    always_comb begin
        state_n = state;
        occ_n   = occ + OW'(wr) - OW'(rd);
        unique case (state)
            EMPTY: begin
                if (wr) state_n = PARTIAL;
            end
            PARTIAL: begin
                if (wr && !rd && occ == OCC_FULL - OCC_ONE)
                    state_n = FULL;
                else if (rd && !wr && occ == OCC_ONE)
                    state_n = EMPTY;
            end
            FULL: begin
                if (rd) state_n = PARTIAL;
            end
            default: state_n = EMPTY;
        endcase
    end

    // Reset forces the producer side open and the consumer side idle.
    always_comb begin
        in_rdy   = RESET || (state != FULL);
        out_send = !RESET && (state != EMPTY);
        wr       = bus.In_SEND && in_rdy;
        rd       = bus.Out_ACK && out_send;
    end

    assign bus.In_RDY    = in_rdy;
    assign bus.In_ACK    = wr;
    assign bus.Out_SEND  = out_send;
    assign bus.Out_COUNT = RESET ? '0 : count_t'(occ);

    token_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .CLK   (CLK),
        .we    (wr && !RESET),
        .waddr (wr_ptr),
        .wdata (bus.In_DATA),
        .raddr (rd_ptr),
        .rdata (bus.Out_DATA)
    );

`ifdef TOKEN_FIFO_ERR_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            Err <= 1'b0;
        else if ((bus.In_SEND && !in_rdy) || (bus.Out_ACK && !out_send))
            Err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_token_fifo.sv
// Directed self-checking bench for token_fifo (DEPTH=8, WIDTH=16).
// Err is checked only when TOKEN_FIFO_ERR_EN is defined.
module tb_token_fifo;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    token_fifo_if #(.WIDTH(16)) bus ();

`ifdef TOKEN_FIFO_ERR_EN
    logic Err;
`endif

    token_fifo #(
        .WIDTH (16),
        .DEPTH (8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
`ifdef TOKEN_FIFO_ERR_EN
        ,
        .Err   (Err)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic send, input logic [15:0] data,
                         input logic ack);
        bus.In_SEND  = send;
        bus.In_DATA  = data;
        bus.Out_ACK  = ack;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        tick();
        RESET = 1'b0;
    endtask

    int rd_idx;

    initial begin
        checks = 0;
        errors = 0;
        RESET = 1'b1;
        bus.In_COUNT = 16'd1;
        drive(1'b0, 16'h0, 1'b0);

        // reset cycle: open input, write offered and acked but discarded
        drive(1'b1, 16'hDEAD, 1'b0);
        chk("rst_in_rdy", 32'(bus.In_RDY), 32'd1);
        chk("rst_in_ack", 32'(bus.In_ACK), 32'd1);
        chk("rst_out_send", 32'(bus.Out_SEND), 32'd0);
        chk("rst_out_count", 32'(bus.Out_COUNT), 32'd0);
        tick();
        RESET = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        chk("rst_discard_count", 32'(bus.Out_COUNT), 32'd0);
        chk("rst_discard_send", 32'(bus.Out_SEND), 32'd0);
`ifdef TOKEN_FIFO_ERR_EN
        chk("rst_err", 32'(Err), 32'd0);
`endif

        // three writes, no consumer
        drive(1'b1, 16'h0011, 1'b0);
        chk("w3_ack0", 32'(bus.In_ACK), 32'd1);
        chk("w3_no_bypass", 32'(bus.Out_SEND), 32'd0);
        tick();
        drive(1'b1, 16'h0022, 1'b0);
        chk("w3_ack1", 32'(bus.In_ACK), 32'd1);
        tick();
        drive(1'b1, 16'h0033, 1'b0);
        chk("w3_ack2", 32'(bus.In_ACK), 32'd1);
        tick();
        drive(1'b0, 16'h0, 1'b0);
        chk("w3_count", 32'(bus.Out_COUNT), 32'd3);
        chk("w3_head", 32'(bus.Out_DATA), 32'h0011);
        chk("w3_send", 32'(bus.Out_SEND), 32'd1);

        // overflow: nine back-to-back writes into depth 8
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 16'(16'h0100 + i), 1'b0);
            chk("fill_rdy", 32'(bus.In_RDY), (i < 8) ? 32'd1 : 32'd0);
            chk("fill_ack", 32'(bus.In_ACK), (i < 8) ? 32'd1 : 32'd0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0);
        chk("full_count", 32'(bus.Out_COUNT), 32'd8);
        chk("full_rdy", 32'(bus.In_RDY), 32'd0);
        chk("full_head", 32'(bus.Out_DATA), 32'h0100);
`ifdef TOKEN_FIFO_ERR_EN
        chk("full_err", 32'(Err), 32'd1);
`endif

        // full with simultaneous send and ack: read wins
        drive(1'b1, 16'hAAAA, 1'b1);
        chk("fullrw_ack", 32'(bus.In_ACK), 32'd0);
        chk("fullrw_rdy", 32'(bus.In_RDY), 32'd0);
        tick();
        drive(1'b1, 16'hAAAA, 1'b0);
        chk("fullrw_count", 32'(bus.Out_COUNT), 32'd7);
        chk("fullrw_retry_ack", 32'(bus.In_ACK), 32'd1);
        tick();
        drive(1'b0, 16'h0, 1'b0);
        chk("refill_count", 32'(bus.Out_COUNT), 32'd8);

        // drain in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0, 1'b1);
            chk("drain_data", 32'(bus.Out_DATA),
                (i < 7) ? 32'(16'h0101 + i) : 32'h0000AAAA);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0);
        chk("drained_count", 32'(bus.Out_COUNT), 32'd0);
        chk("drained_send", 32'(bus.Out_SEND), 32'd0);

        // ack while empty is ignored
        drive(1'b0, 16'h0, 1'b1);
        tick();
        drive(1'b0, 16'h0, 1'b0);
        chk("empty_ack_count", 32'(bus.Out_COUNT), 32'd0);

        // empty with send and ack: write wins
        drive(1'b1, 16'h1234, 1'b1);
        chk("emptyrw_ack", 32'(bus.In_ACK), 32'd1);
        chk("emptyrw_send", 32'(bus.Out_SEND), 32'd0);
        tick();
        drive(1'b0, 16'h0, 1'b0);
        chk("emptyrw_count", 32'(bus.Out_COUNT), 32'd1);
        chk("emptyrw_data", 32'(bus.Out_DATA), 32'h1234);
        drive(1'b0, 16'h0, 1'b1);
        tick();
        drive(1'b0, 16'h0, 1'b0);
        chk("emptyrw_pop", 32'(bus.Out_COUNT), 32'd0);

        // streaming across pointer wrap
        do_reset();
        rd_idx = 0;
        for (int k = 0; k < 22; k++) begin
            drive(k < 20, 16'(16'h2000 + k), k >= 1);
            chk("stream_count_le2", 32'(bus.Out_COUNT <= 16'd2), 32'd1);
            if (bus.Out_SEND && bus.Out_ACK) begin
                chk("stream_data", 32'(bus.Out_DATA), 32'(16'h2000 + rd_idx));
                rd_idx++;
            end
            tick();
        end
        drive(1'b0, 16'h0, 1'b0);
        chk("stream_reads", 32'(rd_idx), 32'd20);
        chk("stream_end_count", 32'(bus.Out_COUNT), 32'd0);

        // reset mid-transfer
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h0500 + i), 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0);
        chk("pre_rst_count", 32'(bus.Out_COUNT), 32'd5);
        do_reset();
        drive(1'b0, 16'h0, 1'b0);
        chk("post_rst_send", 32'(bus.Out_SEND), 32'd0);
        chk("post_rst_count", 32'(bus.Out_COUNT), 32'd0);
        chk("post_rst_rdy", 32'(bus.In_RDY), 32'd1);
        drive(1'b1, 16'h0F0F, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0);
        chk("post_rst_head", 32'(bus.Out_DATA), 32'h0F0F);
        chk("post_rst_count1", 32'(bus.Out_COUNT), 32'd1);
`ifdef TOKEN_FIFO_ERR_EN
        chk("post_rst_err", 32'(Err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/token_fifo.md
TOKEN_FIFO -- requirements
Module: token_fifo

Interface
REQ-001 Parameter WIDTH, default 16, token data width in bits.
REQ-002 Parameter DEPTH, default 8, token capacity; power of two, 2..256.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 In_DATA  in  WIDTH  token offered by the producer actor's output port.
REQ-006 In_SEND  in  1  producer offers one token this cycle.
REQ-007 In_COUNT  in  16  producer token count; only value 1 is supported, and the block ignores it.
REQ-008 In_RDY  out  1  space available; high when occupancy < DEPTH.
REQ-009 In_ACK  out  1  token accepted this cycle.
REQ-010 Out_DATA  out  WIDTH  head token presented to the consumer actor's input port.
REQ-011 Out_SEND  out  1  head token valid; high when occupancy > 0.
REQ-012 Out_COUNT  out  16  current occupancy, zero-extended.
REQ-013 Out_ACK  in  1  consumer takes the head token this cycle.

Function
REQ-014 Write event wr = In_SEND & In_RDY; In_ACK = wr, combinational in the same cycle.
REQ-015 In_SEND while In_RDY=0 is dropped: no state change, In_ACK=0.
REQ-016 Read event rd = Out_ACK & Out_SEND; Out_ACK while empty is ignored.
REQ-017 Occupancy next = occ + wr - rd; wr and rd in the same cycle leave occ unchanged.
REQ-018 Write and read pointers are log2(DEPTH) bits wide and advance on wr and rd respectively, wrapping DEPTH-1 -> 0.
REQ-019 Out_DATA shows the head token combinationally from storage and is stable until rd; its value is don't-care when Out_SEND=0.
REQ-020 Latency: a token accepted at edge N appears at Out_SEND/Out_DATA after edge N; no same-cycle bypass when empty.
REQ-021 Occupancy states: EMPTY (occ=0), PARTIAL (0<occ<DEPTH), FULL (occ=DEPTH).
REQ-022 Transitions: EMPTY->PARTIAL on wr; PARTIAL->FULL on wr&!rd at occ=DEPTH-1; FULL->PARTIAL on rd; PARTIAL->EMPTY on rd&!wr at occ=1.
REQ-023 FULL with In_SEND and Out_ACK both high: the read completes, the write is refused (In_RDY=0 that cycle).
REQ-024 EMPTY with In_SEND and Out_ACK both high: the write completes, the read is ignored.
REQ-025 Tokens leave in strict arrival order; no token is lost or duplicated.

Reset
REQ-026 RESET high at any edge: occ=0, both pointers=0, state EMPTY, even mid-transfer; storage contents are not cleared.
REQ-027 During and after RESET: In_RDY=1, In_ACK=In_SEND (combinational), Out_SEND=0, Out_COUNT=0.
REQ-028 A write offered in the reset cycle is discarded even though In_ACK is high.

Configuration
REQ-029 Macro TOKEN_FIFO_ERR_EN defined: adds output Err (1 bit), which is sticky-set at the edge after either In_SEND while In_RDY=0 or Out_ACK while Out_SEND=0, and is cleared only by RESET.
REQ-030 Macro TOKEN_FIFO_ERR_EN undefined: no Err port and no error logic; the port list is exactly REQ-003..REQ-013.

Structure
REQ-031 Package token_fifo_pkg holds: default WIDTH/DEPTH constants, a pointer-width function (clog2), the occupancy-state enum (EMPTY/PARTIAL/FULL), and the 16-bit count type.
REQ-032 Sub-module token_fifo_mem holds storage: DEPTH x WIDTH, one synchronous write port, one combinational read port; control, pointers and occupancy stay in token_fifo.

Verification
REQ-033 Reset, then write 0x0011, 0x0022, 0x0033 on consecutive cycles with Out_ACK=0 -> In_ACK high for 3 cycles, Out_COUNT=3, Out_DATA=0x0011.
REQ-034 DEPTH=8: write 9 tokens back-to-back -> In_RDY falls after the 8th, 9th token not acked, Out_COUNT=8; with the macro defined, Err=1.
REQ-035 Full, then one cycle with In_SEND=1 (0xAAAA) and Out_ACK=1 -> head popped, 0xAAAA refused, Out_COUNT=7; next cycle 0xAAAA accepted, Out_COUNT=8.
REQ-036 Empty, then one cycle with In_SEND=1 (0x1234) and Out_ACK=1 -> Out_COUNT=1 and Out_DATA=0x1234 next cycle; Out_ACK then pops it and Out_COUNT=0.
REQ-037 Write 20 sequential values while acking continuously from cycle 2 -> output sequence matches input exactly across pointer wrap, and Out_COUNT never exceeds 2.
REQ-038 RESET asserted with Out_COUNT=5 -> next cycle Out_SEND=0, Out_COUNT=0, In_RDY=1; a new write of 0x0F0F is the next head.
